// File: rtl/tytra_ctrl_pkg.sv
// Shared definitions for the work-item sequencers: state encoding and default counter width.
package tytra_ctrl_pkg;

    localparam int CNTW_DEFAULT = 32;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } kd_state_e;

    // A run is in progress while items can still be issued or retired.
    function automatic logic st_active(input kd_state_e s);
        return (s == ST_RUN) || (s == ST_DRAIN);
    endfunction

endpackage

// File: rtl/tytra_sat_counter.sv
// Up-counter that clears on request and holds once it reaches a programmable limit.
module tytra_sat_counter #(
    parameter int W = 32
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clear,
    input  logic         en,
    input  logic [W-1:0] limit,
    output logic [W-1:0] count,
    output logic         at_limit,
    output logic         last_step
);

    logic [W-1:0] count_reg;
    logic [W-1:0] count_next;
    logic [W-1:0] count_inc;

    assign count_inc = count_reg + W'(1);
    assign at_limit  = (count_reg == limit);
    // High in the cycle whose increment lands exactly on the limit.
    assign last_step = en && !at_limit && (count_inc == limit);

    always_comb begin
        count_next = count_reg;
        if (clear) begin
            count_next = '0;
        end else if (en && !at_limit) begin
            count_next = count_inc;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_reg <= '0;
        end else begin
            count_reg <= count_next;
        end
    end

    assign count = count_reg;

endmodule

// File: rtl/kernel_d_kd_ctrl.sv
// Work-item sequencer for a latency-1 leaf kernel: admits exactly n items, counts retirements,
// and pulses done when the last one leaves the kernel.
module kernel_d_kd_ctrl
    import tytra_ctrl_pkg::*;
#(
    parameter int CNTW = CNTW_DEFAULT
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic [CNTW-1:0] size,
    output logic            busy,
    output logic            done,
    input  logic            src_valid,
    output logic            src_ready,
    output logic            k_ivalid,
    input  logic            k_iready,
    input  logic            k_ovalid,
    output logic [CNTW-1:0] issued,
    output logic [CNTW-1:0] retired
);

    kd_state_e       state_reg;
    kd_state_e       state_next;
    logic [CNTW-1:0] n_reg;
    logic            busy_reg;
    logic            done_reg;

    logic            start_acc;
    logic            issue_en;
    logic            retire_en;
    logic            issue_at_limit;
    logic            issue_last;
    logic            retire_at_limit;
    logic            retire_last;

    assign start_acc = (state_reg == ST_IDLE) && start;

    // Gating depends only on the current state and k_iready, so an async reset drops it at once.
    always_comb begin
        src_ready = 1'b0;
        if (state_reg == ST_RUN) begin
            src_ready = k_iready && !issue_at_limit;
        end
    end

    assign k_ivalid  = src_valid && src_ready;
    assign issue_en  = k_ivalid;
    assign retire_en = k_ovalid && st_active(state_reg);

    tytra_sat_counter #(
        .W (CNTW)
    ) u_issue_cnt (
        .clk       (clk),
        .rst       (rst),
        .clear     (start_acc),
        .en        (issue_en),
        .limit     (n_reg),
        .count     (issued),
        .at_limit  (issue_at_limit),
        .last_step (issue_last)
    );

    tytra_sat_counter #(
        .W (CNTW)
    ) u_retire_cnt (
        .clk       (clk),
        .rst       (rst),
        .clear     (start_acc),
        .en        (retire_en),
        .limit     (n_reg),
        .count     (retired),
        .at_limit  (retire_at_limit),
        .last_step (retire_last)
    );

    always_comb begin
        state_next = state_reg;
        unique case (state_reg)
            ST_IDLE: begin
                if (start) begin
                    state_next = (size != '0) ? ST_RUN : ST_DONE;
                end
            end
            ST_RUN: begin
                // A final retire while still issuing skips DRAIN entirely.
                if (retire_last) begin
                    state_next = ST_DONE;
                end else if (issue_last) begin
                    state_next = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                if (retire_last || retire_at_limit) begin
                    state_next = ST_DONE;
                end
            end
            ST_DONE: begin
                state_next = ST_IDLE;
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg <= ST_IDLE;
            n_reg     <= '0;
            busy_reg  <= 1'b0;
            done_reg  <= 1'b0;
        end else begin
            state_reg <= state_next;
            busy_reg  <= st_active(state_next);
            done_reg  <= (state_next == ST_DONE);
            if (start_acc) begin
                n_reg <= size;
            end
        end
    end

    assign busy = busy_reg;
    assign done = done_reg;

endmodule

// File: tb/tb_kernel_d_kd_ctrl.sv
// Directed bench for kernel_d_kd_ctrl with a latency-1 kernel model.
module tb_kernel_d_kd_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [31:0] size;
    logic        busy;
    logic        done;
    logic        src_valid;
    logic        src_ready;
    logic        k_ivalid;
    logic        k_iready;
    logic        k_ovalid = 1'b0;
    logic [31:0] issued;
    logic [31:0] retired;

    int tests = 0;
    int errs  = 0;

    kernel_d_kd_ctrl #(.CNTW(32)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .size      (size),
        .busy      (busy),
        .done      (done),
        .src_valid (src_valid),
        .src_ready (src_ready),
        .k_ivalid  (k_ivalid),
        .k_iready  (k_iready),
        .k_ovalid  (k_ovalid),
        .issued    (issued),
        .retired   (retired)
    );

    always #5 clk = ~clk;

    // Latency-1 kernel: every accepted input appears on ovalid one cycle later.
    always @(posedge clk) k_ovalid <= k_ivalid;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            errs++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    logic        pat3 [5];
    logic [31:0] iexp3 [5];
    logic        rdy4 [8];
    logic [31:0] iexp4 [8];

    initial begin
        pat3  = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
        iexp3 = '{32'd0, 32'd1, 32'd1, 32'd1, 32'd2};
        rdy4  = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1};
        iexp4 = '{32'd0, 32'd1, 32'd1, 32'd1, 32'd1, 32'd2, 32'd3, 32'd4};

        rst = 1'b1; start = 1'b0; size = '0; src_valid = 1'b0; k_iready = 1'b0;
        step(); step();
        rst = 1'b0;
        #1;
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_issued", issued, 0);
        chk("rst_retired", retired, 0);
        chk("rst_src_ready", src_ready, 0);
        $display("[TB] reset checked");

        // Continuous run, size 4
        step(); start = 1'b1; size = 32'd4; src_valid = 1'b1; k_iready = 1'b1; #1;
        chk("t1_idle_src_ready", src_ready, 0);
        for (int t = 1; t <= 7; t++) begin
            step(); start = 1'b0; #1;
            chk($sformatf("t1_busy_c%0d", t), busy, (t <= 5) ? 1 : 0);
            chk($sformatf("t1_done_c%0d", t), done, (t == 6) ? 1 : 0);
            chk($sformatf("t1_issued_c%0d", t), issued, (t <= 4) ? t - 1 : 4);
            chk($sformatf("t1_retired_c%0d", t), retired, (t <= 2) ? 0 : ((t >= 6) ? 4 : t - 2));
            chk($sformatf("t1_k_ivalid_c%0d", t), k_ivalid, (t <= 4) ? 1 : 0);
        end
        $display("[TB] continuous run size=4 done");

        // Zero-length run
        step(); start = 1'b1; size = 32'd0; #1;
        chk("t2_src_ready_c0", src_ready, 0);
        step(); start = 1'b0; #1;
        chk("t2_done_c1", done, 1);
        chk("t2_busy_c1", busy, 0);
        chk("t2_src_ready_c1", src_ready, 0);
        chk("t2_issued_c1", issued, 0);
        step(); #1;
        chk("t2_done_c2", done, 0);
        chk("t2_busy_c2", busy, 0);
        $display("[TB] zero-length run done");

        // Source bubbles, size 3
        step(); start = 1'b1; size = 32'd3; src_valid = 1'b0; #1;
        for (int k = 0; k < 5; k++) begin
            step(); start = 1'b0; src_valid = pat3[k]; #1;
            chk($sformatf("t3_k_ivalid_c%0d", k + 1), k_ivalid, pat3[k]);
            chk($sformatf("t3_issued_c%0d", k + 1), issued, iexp3[k]);
            chk($sformatf("t3_busy_c%0d", k + 1), busy, 1);
        end
        step(); src_valid = 1'b0; #1;
        chk("t3_issued_c6", issued, 3);
        chk("t3_done_c6", done, 0);
        step(); #1;
        chk("t3_done_c7", done, 1);
        chk("t3_retired_c7", retired, 3);
        chk("t3_busy_c7", busy, 0);
        $display("[TB] source-bubble run size=3 done");

        // Back-pressure, size 5
        step(); start = 1'b1; size = 32'd5; src_valid = 1'b1; k_iready = 1'b1; #1;
        for (int k = 0; k < 8; k++) begin
            step(); start = 1'b0; k_iready = rdy4[k]; #1;
            chk($sformatf("t4_src_ready_c%0d", k + 1), src_ready, rdy4[k]);
            chk($sformatf("t4_k_ivalid_c%0d", k + 1), k_ivalid, rdy4[k]);
            chk($sformatf("t4_issued_c%0d", k + 1), issued, iexp4[k]);
        end
        step(); k_iready = 1'b1; #1;
        chk("t4_issued_c9", issued, 5);
        chk("t4_src_ready_c9", src_ready, 0);
        chk("t4_k_ivalid_c9", k_ivalid, 0);
        step(); #1;
        chk("t4_done_c10", done, 1);
        chk("t4_retired_c10", retired, 5);
        $display("[TB] back-pressure run size=5 done");

        // Ignored start mid-run
        step(); start = 1'b1; size = 32'd2; #1;
        step(); start = 1'b1; size = 32'd9; #1;
        chk("t5_issued_c1", issued, 0);
        chk("t5_k_ivalid_c1", k_ivalid, 1);
        step(); start = 1'b0; #1;
        chk("t5_issued_c2", issued, 1);
        chk("t5_k_ivalid_c2", k_ivalid, 1);
        step(); #1;
        chk("t5_issued_c3", issued, 2);
        chk("t5_k_ivalid_c3", k_ivalid, 0);
        chk("t5_busy_c3", busy, 1);
        step(); #1;
        chk("t5_done_c4", done, 1);
        chk("t5_retired_c4", retired, 2);
        step(); #1;
        chk("t5_busy_c5", busy, 0);
        chk("t5_done_c5", done, 0);
        chk("t5_src_ready_c5", src_ready, 0);
        chk("t5_issued_c5", issued, 2);
        $display("[TB] ignored-start run size=2 done");

        // Reset during DRAIN of a size-8 run, then a clean size-2 run
        step(); start = 1'b1; size = 32'd8; #1;
        for (int k = 1; k <= 8; k++) begin
            step(); start = 1'b0;
        end
        step(); #1;
        chk("t6_issued_drain", issued, 8);
        chk("t6_busy_drain", busy, 1);
        chk("t6_k_ivalid_drain", k_ivalid, 0);
        rst = 1'b1; #1;
        chk("t6_rst_busy", busy, 0);
        chk("t6_rst_done", done, 0);
        chk("t6_rst_issued", issued, 0);
        chk("t6_rst_retired", retired, 0);
        chk("t6_rst_src_ready", src_ready, 0);
        chk("t6_rst_k_ivalid", k_ivalid, 0);
        rst = 1'b0; #1;
        step(); #1;
        chk("t6_post_retired", retired, 0);
        chk("t6_post_busy", busy, 0);
        chk("t6_post_done", done, 0);
        step(); start = 1'b1; size = 32'd2; #1;
        step(); start = 1'b0; #1;
        chk("t6_run2_busy_c1", busy, 1);
        step(); step(); step(); #1;
        chk("t6_run2_done_c4", done, 1);
        chk("t6_run2_retired_c4", retired, 2);
        chk("t6_run2_issued_c4", issued, 2);
        $display("[TB] reset mid-run and size=2 rerun done");

        $display("[TB] %0d tests run, %0d failed", tests, errs);
        $finish;
    end

endmodule
